// File: rtl/tt_um_marxkar_seqgen.sv
// Serial pattern generator.
// A shadowed pattern of 1..8 bits is sent MSB-first, repeated 1..16 times.
// Consecutive repetitions are separated by a one-cycle gap, and the run
// ends with a one-cycle done pulse. Outputs are decoded from registered
// state only, so no input has a combinational path to any output.
//
// Handshake: bit_valid is the only qualifier. On each enabled clock cycle
// where bit_valid=1, output_bit carries one pattern bit. No ready signal
// exists, so the consumer must take every valid bit. With ena=0 the block
// freezes and holds the current bit.
module tt_um_marxkar_seqgen (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       load,
   input  logic [7:0] pattern_in,
   input  logic [2:0] length_in,
   input  logic [3:0] repeat_in,
   input  logic       start,
   output logic       output_bit,
   output logic       bit_valid,
   output logic       busy,
   output logic       done,
   output logic [1:0] present_state
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      GAP  = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t     state;
   state_t     next_state;

   logic [7:0] sh_pattern;
   logic [2:0] sh_length;
   logic [3:0] sh_repeat;
   logic [2:0] bit_idx;
   logic [3:0] rpt_cnt;

   // State register; ena=0 freezes the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (ena) begin
         state <= next_state;
      end
   end

   // Next-state logic. start is honoured only in IDLE.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start) next_state = SEND;
         SEND: begin
            if (bit_idx == 3'd0) begin
               next_state = (rpt_cnt != 4'd0) ? GAP : DONE;
            end
         end
         GAP:  next_state = SEND;
         DONE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Shadow registers, bit index and repeat counter.
   // When load and start arrive together, start takes the fresh inputs
   // directly, so this transmission uses the newly loaded values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_pattern <= 8'h0B;
         sh_length  <= 3'd3;
         sh_repeat  <= 4'd0;
         bit_idx    <= 3'd0;
         rpt_cnt    <= 4'd0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (load) begin
                  sh_pattern <= pattern_in;
                  sh_length  <= length_in;
                  sh_repeat  <= repeat_in;
               end
               if (start) begin
                  bit_idx <= load ? length_in : sh_length;
                  rpt_cnt <= load ? repeat_in : sh_repeat;
               end
            end
            SEND: begin
               if (bit_idx != 3'd0) begin
                  bit_idx <= bit_idx - 3'd1;
               end else if (rpt_cnt != 4'd0) begin
                  rpt_cnt <= rpt_cnt - 4'd1;
               end
            end
            GAP: bit_idx <= sh_length;
            default: ;
         endcase
      end
   end

   // Output decode from registered state. Bits above the length are never
   // selected because bit_idx never exceeds the loaded length.
   always_comb begin
      output_bit    = 1'b0;
      bit_valid     = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      present_state = state;
      case (state)
         SEND: begin
            output_bit = sh_pattern[bit_idx];
            bit_valid  = 1'b1;
            busy       = 1'b1;
         end
         GAP:  busy = 1'b1;
         DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_tt_um_marxkar_seqgen.sv
// Testbench for tt_um_marxkar_seqgen.
// A reference model expands each transmission into its bit stream and its
// expected done cycle, and pushes both into queues. A monitor process pops
// and compares entries whenever the DUT presents a valid bit or a done pulse.
module tb_tt_um_marxkar_seqgen;

   localparam int W = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       load = 1'b0;
   logic [7:0] pattern_in = 8'h00;
   logic [2:0] length_in = 3'd0;
   logic [3:0] repeat_in = 4'd0;
   logic       start = 1'b0;
   logic       output_bit;
   logic       bit_valid;
   logic       busy;
   logic       done;
   logic [1:0] present_state;

   tt_um_marxkar_seqgen dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .load(load),
      .pattern_in(pattern_in), .length_in(length_in), .repeat_in(repeat_in),
      .start(start), .output_bit(output_bit), .bit_valid(bit_valid),
      .busy(busy), .done(done), .present_state(present_state)
   );

   // ---------------- clock / reset bookkeeping ----------------
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int en_cyc = 0;        // number of enabled clock edges since time 0
   bit edge_flag = 1'b0;  // last posedge was an enabled, out-of-reset edge

   // Reference model state (the shadowed configuration)
   logic [7:0] sh_p = 8'h0B;
   logic [2:0] sh_l = 3'd3;
   logic [3:0] sh_r = 4'd0;

   // Scoreboard queues
   logic [W-1:0] exp_q[$];
   int           done_q[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      edge_flag = rst_n && ena;
      if (edge_flag) en_cyc++;
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst_n && edge_flag) begin
         if (bit_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_bit", 1, 0);
            end else begin
               chk("output_bit", int'(output_bit), int'(exp_q.pop_front()));
            end
            chk("send_state", int'(present_state), 1);
            chk("send_busy", int'(busy), 1);
         end else begin
            chk("idle_bit_zero", int'(output_bit), 0);
         end
         if (done) begin
            if (done_q.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               chk("done_cycle", en_cyc, done_q.pop_front());
            end
            chk("done_state", int'(present_state), 3);
            chk("bits_left_at_done", exp_q.size(), 0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic reset_model();
      sh_p = 8'h0B;
      sh_l = 3'd3;
      sh_r = 4'd0;
      exp_q.delete();
      done_q.delete();
   endtask

   task automatic chk_reset_outputs();
      chk("rst_output_bit", int'(output_bit), 0);
      chk("rst_bit_valid", int'(bit_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_state", int'(present_state), 0);
   endtask

   task automatic issue_tx(input logic [7:0] p, input logic [2:0] l,
                           input logic [3:0] r, input bit do_load);
      @(negedge clk);
      ena = 1'b1;
      start = 1'b1;
      load = do_load;
      pattern_in = p;
      length_in = l;
      repeat_in = r;
      if (do_load) begin
         sh_p = p;
         sh_l = l;
         sh_r = r;
      end
      for (int k = 0; k <= int'(sh_r); k++)
         for (int i = int'(sh_l); i >= 0; i--)
            exp_q.push_back(sh_p[i]);
      done_q.push_back(en_cyc + (int'(sh_l) + 1) * (int'(sh_r) + 1) + int'(sh_r) + 1);
      @(negedge clk);
      start = 1'b0;
      load = 1'b0;
   endtask

   // Wait for the pending done; with noise, randomly freeze ena (checking
   // that outputs hold) and throw start/load with pattern FF at the busy DUT.
   task automatic wait_done(input bit noise);
      int cnt = 0;
      logic hb = 1'b0;
      logic hv = 1'b0;
      logic [1:0] hs = 2'b00;
      while (done_q.size() != 0 && cnt < 3000) begin
         if (noise) begin
            if (!ena) begin
               chk("hold_output_bit", int'(output_bit), int'(hb));
               chk("hold_bit_valid", int'(bit_valid), int'(hv));
               chk("hold_state", int'(present_state), int'(hs));
               if ($urandom_range(0, 2) == 0) ena = 1'b1;
            end else if ($urandom_range(0, 5) == 0) begin
               ena = 1'b0;
               hb = output_bit;
               hv = bit_valid;
               hs = present_state;
            end
            start = 1'($urandom_range(0, 1));
            load = 1'($urandom_range(0, 1));
            pattern_in = 8'hFF;
            length_in = 3'($urandom);
            repeat_in = 4'($urandom);
         end
         @(negedge clk);
         cnt++;
      end
      start = 1'b0;
      load = 1'b0;
      ena = 1'b1;
      if (done_q.size() != 0) begin
         chk("done_timeout", cnt, 0);
         exp_q.delete();
         done_q.delete();
      end
      @(negedge clk);
      chk("back_to_idle", int'(present_state), 0);
      chk("idle_done_low", int'(done), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Default pattern 1011 right after reset, no load
      issue_tx(8'h00, 3'd0, 3'd0, 1'b0);
      wait_done(1'b0);

      // A5 / length 7 / repeat 1
      issue_tx(8'hA5, 3'd7, 4'd1, 1'b1);
      wait_done(1'b0);

      // load+start together: 01 / length 0 / repeat 2
      issue_tx(8'h01, 3'd0, 4'd2, 1'b1);
      wait_done(1'b0);

      // Freezes and ignored start/load while busy; the shadow must survive
      issue_tx(8'hC3, 3'd5, 4'd1, 1'b1);
      wait_done(1'b1);
      issue_tx(8'h5A, 3'd2, 4'd3, 1'b0);
      wait_done(1'b1);

      // Reset during the second bit of 1011: abort, no done, shadow restored
      @(negedge clk);
      rst_n = 1'b0;
      reset_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue_tx(8'h00, 3'd0, 4'd0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      reset_model();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      issue_tx(8'h77, 3'd1, 4'd9, 1'b0);
      wait_done(1'b0);

      // Randomized transactions
      for (int n = 0; n < 40; n++) begin
         logic [7:0] p;
         logic [2:0] l;
         logic [3:0] r;
         p = 8'($urandom);
         l = 3'($urandom);
         r = 4'($urandom_range(0, 4));
         if ($urandom_range(0, 3) == 0) begin
            // Load alone in IDLE, then a plain start later
            @(negedge clk);
            load = 1'b1;
            pattern_in = p;
            length_in = l;
            repeat_in = r;
            sh_p = p;
            sh_l = l;
            sh_r = r;
            @(negedge clk);
            load = 1'b0;
            issue_tx(8'($urandom), 3'($urandom), 4'($urandom), 1'b0);
         end else begin
            issue_tx(p, l, r, 1'($urandom_range(0, 1)));
         end
         wait_done(1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      chk("final_bits_left", exp_q.size(), 0);
      chk("final_done_left", done_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tt_um_marxkar_seqgen.md
TT_UM_MARXKAR_SEQGEN -- requirements
Module: tt_um_marxkar_seqgen

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  clock enable; 0 freezes all state and registered outputs.
REQ-005 load  input  1  capture pattern_in/length_in/repeat_in into shadow registers.
REQ-006 pattern_in  input  8  pattern to transmit, MSB-first within selected length.
REQ-007 length_in  input  3  pattern length minus one (0 -> 1 bit, 7 -> 8 bits).
REQ-008 repeat_in  input  4  repetitions minus one (0 -> sent once, 15 -> sent 16 times).
REQ-009 start  input  1  begin transmission of the shadowed pattern.
REQ-010 output_bit  output  1  serial data bit, registered.
REQ-011 bit_valid  output  1  high when output_bit carries a pattern bit, registered.
REQ-012 busy  output  1  high in SEND or GAP.
REQ-013 done  output  1  one-cycle completion pulse, high in DONE.
REQ-014 present_state  output  2  current FSM state encoding.

Function
REQ-015 FSM SHALL have states IDLE=00, SEND=01, GAP=10, DONE=11, driven onto present_state.
REQ-016 All transitions and register updates SHALL occur only on clk edges with ena=1.
REQ-017 In IDLE, load=1 SHALL capture pattern_in, length_in, repeat_in into shadow registers.
REQ-018 load SHALL be ignored in SEND, GAP and DONE; shadow registers hold.
REQ-019 In IDLE, start=1 SHALL move to SEND; bit index loaded to length, repeat counter to repeat.
REQ-020 load and start together in IDLE: the newly loaded values SHALL be used for that transmission.
REQ-021 start outside IDLE SHALL be ignored (no queuing).
REQ-022 In SEND, output_bit SHALL equal shadow_pattern[index] and bit_valid=1, index decrementing each cycle.
REQ-023 First bit SHALL appear on output_bit the cycle after the start edge (latency 1).
REQ-024 After index 0: repeat counter nonzero -> GAP, counter decrements; counter zero -> DONE.
REQ-025 GAP SHALL last exactly one cycle with bit_valid=0, output_bit=0, then return to SEND with index reloaded.
REQ-026 DONE SHALL last exactly one cycle with done=1, bit_valid=0, output_bit=0, then go to IDLE.
REQ-027 In IDLE, output_bit=0, bit_valid=0, busy=0, done=0.
REQ-028 Total cycles from start edge to done SHALL be (L+1)(R+1) + R + 1, with L=length, R=repeat codes.
REQ-029 Shadow bits above index length SHALL be ignored.
REQ-030 start in DONE SHALL be ignored; a start in the following IDLE cycle is accepted.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE and output_bit=0, bit_valid=0, busy=0, done=0, present_state=00.
REQ-032 Reset SHALL set shadow pattern=8'h0B, length code=3, repeat code=0 (default pattern 1011).
REQ-033 Reset asserted mid-transmission SHALL abort; no done pulse is produced.
REQ-034 After rst_n deasserts, the block SHALL accept start on the first clk edge with ena=1.

Verification
REQ-035 Reset, start pulse, no load -> output_bit 1,0,1,1 with bit_valid=1 on cycles 1-4; done=1 on cycle 5; IDLE cycle 6.
REQ-036 load pattern 8'hA5, length 7, repeat 1, start -> 10100101, one GAP cycle (bit_valid=0), 10100101, done on cycle 18.
REQ-037 load+start same cycle with pattern 8'h01, length 0, repeat 2 -> 1,gap,1,gap,1, done on cycle 6.
REQ-038 ena=0 for 3 cycles mid-SEND -> output_bit, bit_valid, present_state held; sequence resumes unchanged.
REQ-039 start and load (pattern 8'hFF) asserted while busy -> ignored; current pattern completes; shadow unchanged.
REQ-040 rst_n low during bit 2 of 1011 -> outputs 0 immediately, no done pulse, shadow back to 8'h0B/3/0.
